// File: rtl/apb4_ram_slave.sv
// apb4_ram_slave: APB4 completer backed by a word-organised RAM.
// Setup/access decode, WAIT_STATES wait cycles on PREADY, PSTRB byte lanes on writes,
// registered PRDATA on reads, and PSLVERR for misaligned or out-of-range accesses.
// Optional feature macro: APB_PROT_CHECK_EN. When defined, an access whose latched PPROT[0] is 0
// (unprivileged) is answered with an error.
module apb4_ram_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic [DATA_WIDTH-1:0]   PRDATA
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_W      = $clog2(MEM_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   // FSM state
   state_e                state_q, state_d;

   // Transfer attributes captured in the setup phase
   logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] strb_q,  strb_d;
   logic                  priv_q,  priv_d;

   // Wait-state counter and registered bus outputs
   logic [3:0]            cnt_q,     cnt_d;
   logic                  pready_q,  pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;

   // Word-organised storage
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Bus events decoded from the current state and the APB control inputs
   logic                  setup;
   logic                  abort;
   logic                  done;

   // Completion-side signals
   logic                  raise;
   logic                  err_d;
   logic [IDX_W-1:0]      rd_idx;
   logic [IDX_W-1:0]      wr_idx;
   logic                  mem_we;

   // Privilege bit fed into the setup-phase latch
   logic                  priv_in;
   logic                  unused_prot;

`ifdef APB_PROT_CHECK_EN
   assign priv_in     = PPROT[0];
   assign unused_prot = ^PPROT[2:1];
`else
   // Without the protection check every access is treated as privileged.
   assign priv_in     = 1'b1;
   assign unused_prot = ^PPROT;
`endif

   // Error decode on a captured transfer: misaligned, beyond the RAM, or unprivileged.
   function automatic logic access_err(input logic [ADDR_WIDTH-1:0] addr, input logic priv);
      logic misaligned;
      logic out_of_range;
      misaligned   = |addr[1:0];
      out_of_range = (addr >> (IDX_W + 2)) != '0;
      return misaligned | out_of_range | ~priv;
   endfunction

   // State register and all bus-side flops, cleared asynchronously by PRESET
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         priv_q    <= 1'b0;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values present before the edge.
         state_q   <= state_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         priv_q    <= priv_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   // Next-state logic and decode of setup / abort / completion events
   always_comb begin
      state_d = state_q;
      setup   = 1'b0;
      abort   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Any selected cycle in IDLE starts a transfer, even if PENABLE is already high.
            if (PSEL) begin
               setup = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               abort = 1'b1;
            end else if (!PENABLE) begin
               // A fresh setup phase mid-transfer discards the transfer in flight.
               setup = 1'b1;
            end else if (pready_q) begin
               done = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (setup) begin
         state_d = ST_ACCESS;
      end else if (abort || done) begin
         state_d = ST_IDLE;
      end
   end

   // Output and datapath logic: capture, wait count, and the response on the PREADY-raising edge
   always_comb begin
      // NOTE: every _d starts from its _q (hold) so no branch can leave a latch behind.
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      priv_d    = priv_q;
      cnt_d     = cnt_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      raise     = 1'b0;

      if (setup) begin
         addr_d    = PADDR;
         write_d   = PWRITE;
         wdata_d   = PWDATA;
         strb_d    = PSTRB;
         priv_d    = priv_in;
         cnt_d     = 4'(WAIT_STATES);
         raise     = (WAIT_STATES == 0);
         pready_d  = raise;
         pslverr_d = 1'b0;
      end else if (abort || done) begin
         cnt_d     = '0;
         pready_d  = 1'b0;
         pslverr_d = 1'b0;
      end else if (state_q == ST_ACCESS) begin
         // Waiting: PSEL and PENABLE high, PREADY still low.
         cnt_d    = cnt_q - 4'd1;
         raise    = (cnt_q == 4'd1);
         pready_d = raise;
      end

      // The response is decided from the captured attributes on the edge that raises PREADY.
      err_d  = access_err(addr_d, priv_d);
      rd_idx = addr_d[IDX_W+1:2];
      if (raise) begin
         pslverr_d = err_d;
         if (err_d) begin
            prdata_d = '0;
         end else if (!write_d) begin
            prdata_d = mem[rd_idx];
         end
      end
   end

   // Write commit happens only on a clean completion edge; PSLVERR then holds the error verdict.
   assign wr_idx = addr_q[IDX_W+1:2];
   assign mem_we = done && write_q && !pslverr_q;

   // RAM write port with per-byte enables
   always_ff @(posedge PCLK) begin
      // NOTE: the RAM array has no reset; its contents survive PRESET and it maps onto plain RAM.
      if (mem_we) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb_q[i]) begin
               mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign PRDATA  = prdata_q;

`ifndef SYNTHESIS
   // An error response is only ever presented together with PREADY.
   a_slverr_with_ready : assert property (@(posedge PCLK) disable iff (PRESET)
      pslverr_q |-> pready_q);
`endif

endmodule

// File: tb/tb_apb4_ram_slave.sv
// tb_apb4_ram_slave: scoreboard bench for apb4_ram_slave.
// Three instances share one bus: WAIT_STATES = 0, 2 and 3, each with its own PSEL.
// Honours APB_PROT_CHECK_EN for the privilege-check expectations.
module tb_apb4_ram_slave;

   localparam logic [2:0] PROT_OK = 3'b001;
`ifdef APB_PROT_CHECK_EN
   localparam bit PROT_CHK = 1'b1;
`else
   localparam bit PROT_CHK = 1'b0;
`endif

   typedef struct packed {
      logic        err;
      logic        is_read;
      logic [31:0] rdata;
      logic [31:0] lat;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [2:0]       psel;
   logic             penable;
   logic             pwrite;
   logic [31:0]      paddr;
   logic [31:0]      pwdata;
   logic [3:0]       pstrb;
   logic [2:0]       pprot;
   logic [2:0]       pready;
   logic [2:0]       pslverr;
   logic [2:0][31:0] prdata;

   int   n_checks;
   int   n_pass;
   exp_t sb_q[$];

   apb4_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PREADY(pready[0]), .PSLVERR(pslverr[0]), .PRDATA(prdata[0])
   );

   apb4_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut_ws2 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PREADY(pready[1]), .PSLVERR(pslverr[1]), .PRDATA(prdata[1])
   );

   apb4_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut_ws3 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PREADY(pready[2]), .PSLVERR(pslverr[2]), .PRDATA(prdata[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : (d == 1) ? 2 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      psel    = '0;
      penable = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One APB transfer on instance d. Called right after a posedge (+#1); returns the same way,
   // just after the completion edge, with PENABLE low and PSEL still set for back-to-back use.
   task automatic apb(input string tag, input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      input logic exp_err, input logic [31:0] exp_rd);
      exp_t e;
      int   lat;
      e.err     = exp_err;
      e.is_read = !wr;
      e.rdata   = exp_err ? 32'h0 : exp_rd;
      e.lat     = 32'(ws_of(d) + 1);
      sb_q.push_back(e);

      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      pprot   = prot;
      @(posedge clk);
      #1;
      penable = 1'b1;
      pwdata  = ~data;  // must be ignored: write data comes from the setup phase
      lat     = 1;
      @(negedge clk);
      while (!pready[d] && lat < 40) begin
         check({tag, " slverr while waiting"}, 32'(pslverr[d]), 32'd0);
         @(posedge clk);
         #1;
         lat++;
         @(negedge clk);
      end

      e = sb_q.pop_front();
      check({tag, " ready"}, 32'(pready[d]), 32'd1);
      check({tag, " latency"}, 32'(lat), e.lat);
      check({tag, " slverr"}, 32'(pslverr[d]), 32'(e.err));
      if (e.is_read) begin
         check({tag, " rdata"}, prdata[d], e.rdata);
      end
      @(posedge clk);
      #1;
      penable = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      psel     = '0;
      penable  = 1'b0;
      pwrite   = 1'b0;
      paddr    = '0;
      pwdata   = '0;
      pstrb    = '0;
      pprot    = PROT_OK;

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset pready d%0d", d), 32'(pready[d]), 32'd0);
         check($sformatf("reset pslverr d%0d", d), 32'(pslverr[d]), 32'd0);
         check($sformatf("reset prdata d%0d", d), prdata[d], 32'h0);
      end
      rst = 1'b0;
      idle(1);

      // Basic write / read, zero wait states
      apb("wr 0x10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, PROT_OK, 1'b0, 32'h0);
      apb("rd 0x10", 0, 1'b0, 32'h10, 32'h0,        4'hF, PROT_OK, 1'b0, 32'hDEADBEEF);
      idle(1);

      // Byte strobes, including the all-zero strobe no-op
      apb("wr 0x20 full",  0, 1'b1, 32'h20, 32'h11223344, 4'hF,    PROT_OK, 1'b0, 32'h0);
      apb("wr 0x20 strb",  0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, PROT_OK, 1'b0, 32'h0);
      apb("rd 0x20",       0, 1'b0, 32'h20, 32'h0,        4'hF,    PROT_OK, 1'b0, 32'h11BB33DD);
      apb("wr 0x20 nostrb",0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0,    PROT_OK, 1'b0, 32'h0);
      apb("rd 0x20 again", 0, 1'b0, 32'h20, 32'h0,        4'hF,    PROT_OK, 1'b0, 32'h11BB33DD);
      idle(2);

      // Error responses: out of range, misaligned; 0x400 aliases word 0 if the range check is missing
      apb("wr 0x0",        0, 1'b1, 32'h0,   32'hCAFEF00D, 4'hF, PROT_OK, 1'b0, 32'h0);
      apb("wr 0x400 err",  0, 1'b1, 32'h400, 32'h0BADBAD0, 4'hF, PROT_OK, 1'b1, 32'h0);
      apb("rd 0x402 err",  0, 1'b0, 32'h402, 32'h0,        4'hF, PROT_OK, 1'b1, 32'h0);
      apb("rd 0x0 legal",  0, 1'b0, 32'h0,   32'h0,        4'hF, PROT_OK, 1'b0, 32'hCAFEF00D);
      apb("wr 0x21 err",   0, 1'b1, 32'h21,  32'h55555555, 4'hF, PROT_OK, 1'b1, 32'h0);
      apb("rd 0x20 kept",  0, 1'b0, 32'h20,  32'h0,        4'hF, PROT_OK, 1'b0, 32'h11BB33DD);
      idle(1);

      // Privilege check on the captured PPROT[0]
      apb("wr 0x8 base",   0, 1'b1, 32'h8, 32'h12345678, 4'hF, PROT_OK, 1'b0, 32'h0);
      apb("wr 0x8 unpriv", 0, 1'b1, 32'h8, 32'h00000005, 4'hF, 3'b000,  PROT_CHK, 32'h0);
      apb("rd 0x8 a",      0, 1'b0, 32'h8, 32'h0,        4'hF, PROT_OK, 1'b0,
          PROT_CHK ? 32'h12345678 : 32'h00000005);
      apb("wr 0x8 priv",   0, 1'b1, 32'h8, 32'h00000005, 4'hF, 3'b001,  1'b0, 32'h0);
      apb("rd 0x8 b",      0, 1'b0, 32'h8, 32'h0,        4'hF, PROT_OK, 1'b0, 32'h00000005);
      idle(2);

      // Three wait states, back-to-back write then read
      apb("ws3 wr 0x44", 2, 1'b1, 32'h44, 32'h01020304, 4'hF, PROT_OK, 1'b0, 32'h0);
      apb("ws3 rd 0x44", 2, 1'b0, 32'h44, 32'h0,        4'hF, PROT_OK, 1'b0, 32'h01020304);
      apb("ws3 rd 0x402",2, 1'b0, 32'h402,32'h0,        4'hF, PROT_OK, 1'b1, 32'h0);
      idle(2);

      // Aborted write with two wait states: PSEL dropped in the first access cycle
      apb("ws2 wr 0x30", 1, 1'b1, 32'h30, 32'h30303030, 4'hF, PROT_OK, 1'b0, 32'h0);
      idle(1);
      psel    = '0;
      psel[1] = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h30;
      pwdata  = 32'hFFFFFFFF;
      pstrb   = 4'hF;
      pprot   = PROT_OK;
      @(posedge clk);
      #1;
      psel = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("abort pready cyc%0d", i), 32'(pready[1]), 32'd0);
      end
      idle(1);
      apb("ws2 rd 0x30 after abort", 1, 1'b0, 32'h30, 32'h0, 4'hF, PROT_OK, 1'b0, 32'h30303030);
      idle(1);

      // Reset asserted while a read response is on the bus
      psel    = '0;
      psel[1] = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'h30;
      pstrb   = 4'h0;
      @(posedge clk);
      #1;
      penable = 1'b1;
      lat     = 1;
      while (!pready[1] && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("mid-read pready before reset", 32'(pready[1]), 32'd1);
      check("mid-read prdata before reset", prdata[1], 32'h30303030);
      #2;
      rst = 1'b1;
      #1;
      check("async reset pready", 32'(pready[1]), 32'd0);
      check("async reset pslverr", 32'(pslverr[1]), 32'd0);
      check("async reset prdata", prdata[1], 32'h0);
      @(posedge clk);
      #1;
      psel    = '0;
      penable = 1'b0;
      rst     = 1'b0;
      idle(2);

      // RAM contents survive the reset
      apb("ws2 rd 0x30 after reset", 1, 1'b0, 32'h30, 32'h0, 4'hF, PROT_OK, 1'b0, 32'h30303030);
      apb("ws0 rd 0x10 after reset", 0, 1'b0, 32'h10, 32'h0, 4'hF, PROT_OK, 1'b0, 32'hDEADBEEF);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
